// File: rtl/arriskv_pipe_ctrl.sv
// In-order N-stage pipeline controller: carries {pc, rd, rd_we} per stage with
// valid/ready backpressure, bubble collapsing, redirect flush and RAW-hazard stall.
module arriskv_pipe_ctrl #(
    parameter int N_STAGES = 3,
    parameter int WD_PC    = 32,
    parameter int N_REGS   = 32,
    parameter int FWD_EN   = 1,
    localparam int AW      = $clog2(N_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [WD_PC-1:0]          i_in_pc,
    input  logic [AW-1:0]             i_in_rs1,
    input  logic [AW-1:0]             i_in_rs2,
    input  logic [1:0]                i_in_rs_used,
    input  logic [AW-1:0]             i_in_rd,
    input  logic                      i_in_rd_we,
    input  logic                      i_flush,
    output logic [N_STAGES-1:0]       o_stage_valid,
    output logic [N_STAGES*WD_PC-1:0] o_stage_pc,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [WD_PC-1:0]          o_out_pc,
    output logic [AW-1:0]             o_out_rd,
    output logic                      o_out_rd_we,
    output logic                      o_hazard_stall,
    output logic [31:0]               o_retire_cnt
);

    // Stages whose destination must be compared against incoming sources.
    localparam int N_CHK = (FWD_EN != 0) ? N_STAGES - 1 : N_STAGES;

    logic [N_STAGES-1:0] valid_q;
    logic [WD_PC-1:0]    pc_q    [N_STAGES];
    logic [AW-1:0]       rd_q    [N_STAGES];
    logic                rd_we_q [N_STAGES];
    logic [31:0]         retire_cnt_q;

    logic [N_STAGES-1:0] adv;
    logic                hazard;
    logic                accept;
    logic                retire;

    // Advance chain: a stage may move when it is empty or the stage after it
    // moves, so bubbles anywhere collapse within one cycle.
    always_comb begin
        logic a;
        adv = '0;
        a = !valid_q[N_STAGES-1] || i_out_ready;
        adv[N_STAGES-1] = a;
        for (int k = N_STAGES - 2; k >= 0; k--) begin
            a = !valid_q[k] || a;
            adv[k] = a;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < N_STAGES; k++) begin
            if (k < N_CHK && valid_q[k] && rd_we_q[k] && rd_q[k] != '0) begin
                if (i_in_rs_used[0] && i_in_rs1 != '0 && rd_q[k] == i_in_rs1)
                    hazard = 1'b1;
                if (i_in_rs_used[1] && i_in_rs2 != '0 && rd_q[k] == i_in_rs2)
                    hazard = 1'b1;
            end
        end
    end

    // Handshakes: input transfers when i_in_valid && o_in_ready, output
    // retires when o_out_valid && i_out_ready; ready never looks at valid.
    always_comb begin
        o_in_ready     = !rst && adv[0] && !hazard && !i_flush;
        o_hazard_stall = i_in_valid && hazard && !rst;
        accept         = i_in_valid && o_in_ready;
        retire         = valid_q[N_STAGES-1] && i_out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            retire_cnt_q <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                pc_q[k]    <= '0;
                rd_q[k]    <= '0;
                rd_we_q[k] <= 1'b0;
            end
        end else begin
            if (retire)
                retire_cnt_q <= retire_cnt_q + 32'd1;
            if (i_flush) begin
                // Younger stages die; the oldest only retires or holds.
                valid_q[N_STAGES-2:0] <= '0;
                valid_q[N_STAGES-1]   <= valid_q[N_STAGES-1] && !i_out_ready;
            end else begin
                if (adv[0])
                    valid_q[0] <= accept;
                if (accept) begin
                    pc_q[0]    <= i_in_pc;
                    rd_q[0]    <= i_in_rd;
                    rd_we_q[0] <= i_in_rd_we;
                end
                for (int k = 1; k < N_STAGES; k++) begin
                    if (adv[k]) begin
                        valid_q[k] <= valid_q[k-1];
                        if (valid_q[k-1]) begin
                            pc_q[k]    <= pc_q[k-1];
                            rd_q[k]    <= rd_q[k-1];
                            rd_we_q[k] <= rd_we_q[k-1];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage_pc
        assign o_stage_pc[g*WD_PC +: WD_PC] = pc_q[g];
    end

    assign o_stage_valid = valid_q;
    assign o_out_valid   = valid_q[N_STAGES-1];
    assign o_out_pc      = pc_q[N_STAGES-1];
    assign o_out_rd      = rd_q[N_STAGES-1];
    assign o_out_rd_we   = valid_q[N_STAGES-1] && rd_we_q[N_STAGES-1];
    assign o_retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_arriskv_pipe_ctrl.sv
// Directed bench for arriskv_pipe_ctrl: one forwarding instance (FWD_EN=1) and
// one fully-checked instance (FWD_EN=0) share all inputs.
module tb_arriskv_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        i_in_valid;
    logic [31:0] i_in_pc;
    logic [4:0]  i_in_rs1;
    logic [4:0]  i_in_rs2;
    logic [1:0]  i_in_rs_used;
    logic [4:0]  i_in_rd;
    logic        i_in_rd_we;
    logic        i_flush;
    logic        i_out_ready;

    logic        in_ready0, out_valid0, out_rd_we0, stall0;
    logic [2:0]  stage_valid0;
    logic [95:0] stage_pc0;
    logic [31:0] out_pc0, retire_cnt0;
    logic [4:0]  out_rd0;

    logic        in_ready1, out_valid1, out_rd_we1, stall1;
    logic [2:0]  stage_valid1;
    logic [95:0] stage_pc1;
    logic [31:0] out_pc1, retire_cnt1;
    logic [4:0]  out_rd1;

    int tests = 0;
    int fails = 0;
    int st0   = 0;
    int st1   = 0;

    arriskv_pipe_ctrl #(.N_STAGES(3), .WD_PC(32), .N_REGS(32), .FWD_EN(1)) dut0 (
        .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .o_in_ready(in_ready0),
        .i_in_pc(i_in_pc), .i_in_rs1(i_in_rs1), .i_in_rs2(i_in_rs2),
        .i_in_rs_used(i_in_rs_used), .i_in_rd(i_in_rd), .i_in_rd_we(i_in_rd_we),
        .i_flush(i_flush), .o_stage_valid(stage_valid0), .o_stage_pc(stage_pc0),
        .o_out_valid(out_valid0), .i_out_ready(i_out_ready), .o_out_pc(out_pc0),
        .o_out_rd(out_rd0), .o_out_rd_we(out_rd_we0), .o_hazard_stall(stall0),
        .o_retire_cnt(retire_cnt0)
    );

    arriskv_pipe_ctrl #(.N_STAGES(3), .WD_PC(32), .N_REGS(32), .FWD_EN(0)) dut1 (
        .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .o_in_ready(in_ready1),
        .i_in_pc(i_in_pc), .i_in_rs1(i_in_rs1), .i_in_rs2(i_in_rs2),
        .i_in_rs_used(i_in_rs_used), .i_in_rd(i_in_rd), .i_in_rd_we(i_in_rd_we),
        .i_flush(i_flush), .o_stage_valid(stage_valid1), .o_stage_pc(stage_pc1),
        .o_out_valid(out_valid1), .i_out_ready(i_out_ready), .o_out_pc(out_pc1),
        .o_out_rd(out_rd1), .o_out_rd_we(out_rd_we1), .o_hazard_stall(stall1),
        .o_retire_cnt(retire_cnt1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] used, input logic [4:0] rd, input logic we);
        i_in_valid   = 1'b1;
        i_in_pc      = pc;
        i_in_rs1     = rs1;
        i_in_rs2     = rs2;
        i_in_rs_used = used;
        i_in_rd      = rd;
        i_in_rd_we   = we;
    endtask

    task automatic idle();
        i_in_valid   = 1'b0;
        i_in_rs_used = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        i_flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_in_valid = 1'b0; i_in_pc = '0; i_in_rs1 = '0; i_in_rs2 = '0;
        i_in_rs_used = '0; i_in_rd = '0; i_in_rd_we = 1'b0;
        i_flush = 1'b0; i_out_ready = 1'b0;
        tick();
        tick();

        // reset state, with an offer present while rst=1
        offer(32'h40, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1);
        @(negedge clk);
        chk("rst_in_ready", in_ready0, 1'b0);
        chk("rst_stall", stall0, 1'b0);
        chk("rst_stage_valid", stage_valid0, 3'b000);
        chk("rst_stage_pc", stage_pc0, 96'h0);
        chk("rst_retire_cnt", retire_cnt0, 32'h0);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out_rd_we", out_rd_we0, 1'b0);
        tick();
        rst = 1'b0;
        idle();

        // back-to-back stream, no dependencies
        i_out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) offer(32'(4 * k), 5'd0, 5'd0, 2'b00, 5'(k + 1), 1'b1);
            else idle();
            @(negedge clk);
            if (k < 8) chk("stream_in_ready", in_ready0, 1'b1);
            chk("stream_out_valid", out_valid0, (k >= 3));
            if (k >= 3) begin
                chk("stream_out_pc", out_pc0, 32'(4 * (k - 3)));
                chk("stream_out_rd", out_rd0, 5'(k - 2));
                chk("stream_out_rd_we", out_rd_we0, 1'b1);
            end
            tick();
        end
        @(negedge clk);
        chk("stream_retire_cnt", retire_cnt0, 32'd8);
        tick();

        // backpressure: i_out_ready=0 for five cycles
        i_out_ready = 1'b0;
        offer(32'h100, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h104, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h108, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h10C, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready0, 1'b0);
            chk("bp_stage_valid", stage_valid0, 3'b111);
            chk("bp_stage_pc", stage_pc0, {32'h100, 32'h104, 32'h108});
            chk("bp_out_pc", out_pc0, 32'h100);
            tick();
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", in_ready0, 1'b1);
        chk("bp_resume_pc0", out_pc0, 32'h100);
        tick();
        idle();
        @(negedge clk); chk("bp_resume_pc1", out_pc0, 32'h104); tick();
        @(negedge clk); chk("bp_resume_pc2", out_pc0, 32'h108); tick();
        @(negedge clk); chk("bp_resume_pc3", out_pc0, 32'h10C); tick();
        @(negedge clk);
        chk("bp_drained", out_valid0, 1'b0);
        chk("bp_retire_cnt", retire_cnt0, 32'd12);

        // RAW hazard: write x5 then read x5
        do_reset();
        i_out_ready = 1'b1;
        offer(32'h200, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1);
        @(negedge clk);
        chk("haz_writer_ready0", in_ready0, 1'b1);
        chk("haz_writer_ready1", in_ready1, 1'b1);
        tick();
        for (int r = 0; r < 4; r++) begin
            offer(32'h204, 5'd5, 5'd0, 2'b01, 5'd6, 1'b0);
            @(negedge clk);
            chk("haz_stall_fwd", stall0, (r < 2));
            chk("haz_stall_nofwd", stall1, (r < 3));
            chk("haz_ready_fwd", in_ready0, (r >= 2));
            chk("haz_ready_nofwd", in_ready1, (r == 3));
            if (r == 2) begin
                chk("haz_writer_last_valid", out_valid0, 1'b1);
                chk("haz_writer_last_pc", out_pc0, 32'h200);
                chk("haz_writer_last_rd", out_rd0, 5'd5);
            end
            if (stall0) st0++;
            if (stall1) st1++;
            tick();
        end
        idle();
        chk("haz_cycles_fwd", st0, 2);
        chk("haz_cycles_nofwd", st1, 3);

        // x0 source and unused source never stall; used rs2 does
        do_reset();
        offer(32'h300, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1);
        tick();
        offer(32'h304, 5'd0, 5'd7, 2'b01, 5'd9, 1'b0);
        @(negedge clk);
        chk("x0_stall", stall0, 1'b0);
        chk("x0_stall_nofwd", stall1, 1'b0);
        chk("x0_ready", in_ready0, 1'b1);
        tick();
        offer(32'h308, 5'd0, 5'd7, 2'b10, 5'd9, 1'b0);
        @(negedge clk);
        chk("rs2_stall", stall0, 1'b1);
        chk("rs2_ready", in_ready0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("idle_no_stall", stall0, 1'b0);

        // flush against a full, blocked pipeline
        do_reset();
        i_out_ready = 1'b0;
        offer(32'h400, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h404, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h408, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h40C, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0);
        i_flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready0, 1'b0);
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        chk("flush_stage_valid", stage_valid0, 3'b100);
        chk("flush_last_pc", out_pc0, 32'h400);
        chk("flush_reoffer_ready", in_ready0, 1'b1);
        tick();
        idle();
        i_out_ready = 1'b1;
        @(negedge clk);
        chk("flush_after_load", stage_valid0, 3'b101);
        tick();
        @(negedge clk);
        chk("flush_after_retire", stage_valid0, 3'b010);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        chk("flush_ready_hi_valid", stage_valid0, 3'b000);
        chk("flush_retire_cnt", retire_cnt0, 32'd1);

        // retire counter wrap
        do_reset();
        i_out_ready = 1'b1;
        offer(32'h500, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1);
        tick();
        idle();
        force dut0.retire_cnt_q = 32'hFFFF_FFFF;
        tick();
        tick();
        release dut0.retire_cnt_q;
        @(negedge clk);
        chk("wrap_out_valid", out_valid0, 1'b1);
        chk("wrap_pre", retire_cnt0, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("wrap_post", retire_cnt0, 32'h0);
        tick();

        // reset in the middle of a stream
        offer(32'h600, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h604, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0); tick();
        offer(32'h608, 5'd0, 5'd0, 2'b00, 5'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready0, 1'b0);
        chk("midrst_stall", stall0, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("midrst_stage_valid", stage_valid0, 3'b000);
        chk("midrst_retire_cnt", retire_cnt0, 32'h0);
        chk("midrst_out_valid", out_valid0, 1'b0);
        tick();
        @(negedge clk);
        chk("midrst_idle", stage_valid0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
